// File: rtl/sd_fifo_byte_reader.sv
// sd_fifo_byte_reader: prefetching drain of the SD data FIFO into a byte stream.
// Optional SD_RD_MSB_FIRST_EN selects big-endian lane order within each word.
module sd_fifo_byte_reader #(
  parameter int WIDTH     = 32,
  parameter int BLK_BYTES = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last
);

  localparam int NB = WIDTH / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(NB - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLK_BYTES - 1);

  logic             run;
  logic [1:0]       occ;
  logic             inflight;
  logic [LW-1:0]    lane;
  logic [BW-1:0]    bcnt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  logic             hs;
  logic             pop;
  logic [1:0]       occ_keep;
  logic [1:0]       occ_nxt;

  assign m_valid  = (occ != 2'd0);
  assign hs       = m_valid & m_ready;
  assign pop      = hs & (lane == LANE_MAX);
  assign occ_keep = occ - {1'b0, pop};
  assign occ_nxt  = occ_keep + {1'b0, inflight};
  assign m_last   = m_valid & (bcnt == BCNT_MAX);

  // A slot freed by this cycle's pop can be refilled by a read issued now.
  assign fifo_rd_en = run & ~flush & ~fifo_empty & (occ_nxt < 2'd2);

  // Select the byte at the current lane of the head word.
  always_comb begin
    m_data = head[7:0];
    for (int i = 0; i < NB; i++) begin
      if (lane == LW'(i)) begin
`ifdef SD_RD_MSB_FIRST_EN
        m_data = head[(NB-1-i)*8 +: 8];
`else
        m_data = head[i*8 +: 8];
`endif
      end
    end
  end

  // Control state: occupancy, read-in-flight, lane and block counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      lane     <= '0;
      bcnt     <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        occ      <= 2'd0;
        inflight <= 1'b0;
        lane     <= '0;
        bcnt     <= '0;
      end else begin
        occ      <= occ_nxt;
        inflight <= fifo_rd_en;
        if (hs) begin
          lane <= pop ? '0 : lane + 1'b1;
          bcnt <= (bcnt == BCNT_MAX) ? '0 : bcnt + 1'b1;
        end
      end
    end
  end

  // Two-entry word buffer; capture goes to the first slot free after a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      if (pop)
        head <= tail;
      if (inflight) begin
        if (occ_keep == 2'd0)
          head <= fifo_dout;
        else
          tail <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_sd_fifo_byte_reader.sv
// tb_sd_fifo_byte_reader: table vectors, hand sequences and a queue-based
// byte-stream model against a behavioural 1-cycle-latency FIFO.
module tb_sd_fifo_byte_reader;

  localparam int WIDTH = 32;
  localparam int BLK   = 512;
  localparam int NB    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [7:0]       m_data;
  logic             m_last;

  logic [WIDTH-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int rd_err = 0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  int blk_idx = 0;

  typedef struct {
    logic [WIDTH-1:0] w;
    logic [7:0]       b [4];
  } vec_t;
  vec_t tv [4];

  sd_fifo_byte_reader #(.WIDTH(WIDTH), .BLK_BYTES(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) begin
        rd_err <= rd_err + 1;
      end else begin
        fifo_dout <= mem[rd_ptr & 4095];
        rd_ptr    <= rd_ptr + 1;
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_raw(input logic [WIDTH-1:0] w);
    mem[wr_ptr & 4095] = w;
    wr_ptr++;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    push_raw(w);
    for (int i = 0; i < NB; i++) begin
`ifdef SD_RD_MSB_FIRST_EN
      exp_q.push_back(w[(NB-1-i)*8 +: 8]);
`else
      exp_q.push_back(w[i*8 +: 8]);
`endif
    end
  endtask

  task automatic take(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra"}, 32'(m_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(m_data), 32'(e));
      chk({tag, "_last"}, 32'(m_last), (blk_idx == BLK - 1) ? 32'd1 : 32'd0);
      blk_idx = (blk_idx + 1) % BLK;
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc < 10) ? 1'b0 : cyc[0];
    return ($urandom_range(3) != 0);
  endfunction

  task automatic run_stream(input int mode, input int nwords,
                            input int budget, input string tag,
                            output int nlast);
    int cyc = 0;
    int pushed = 0;
    int first = -1;
    int lastc = -1;
    int nbytes = 0;
    int done_w = 0;
    int base;
    bit pstall;
    logic [7:0] pd;
    logic pl;
    nlast = 0;
    @(negedge clk);
    base = rd_cnt;
    if (mode != 2) begin
      for (int i = 0; i < nwords; i++) push_word($urandom);
      pushed = nwords;
    end
    m_ready = ready_for(mode, 0);
    while ((exp_q.size() > 0 || pushed < nwords) && cyc < budget) begin
      pstall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid && m_ready) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        nbytes++;
        if (m_last) nlast++;
        take(tag);
        if (nbytes % NB == 0) done_w++;
      end
      @(negedge clk);
      cyc++;
      if (pstall) begin
        chk({tag, "_stall_data"}, 32'(m_data), 32'(pd));
        chk({tag, "_stall_last"}, 32'(m_last), 32'(pl));
      end
      if (mode != 0)
        chk({tag, "_outstanding"}, 32'((rd_cnt - base - done_w) <= 2), 32'd1);
      if (mode == 2 && pushed < nwords && $urandom_range(2) == 0) begin
        push_word($urandom);
        pushed++;
      end
      m_ready = ready_for(mode, cyc);
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_drained"}, 32'(m_valid), 32'd0);
    if (mode == 0 && nbytes > 0)
      chk({tag, "_nogap"}, 32'(lastc - first + 1), 32'(nbytes));
  endtask

  initial begin
    int nl;
    int base;
    int hsn;
    bit hit;
    bit seen_v;

    tv[0].w = 32'h44332211; tv[0].b = '{8'h11, 8'h22, 8'h33, 8'h44};
    tv[1].w = 32'hDEADBEEF; tv[1].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tv[2].w = 32'h00000000; tv[2].b = '{8'h00, 8'h00, 8'h00, 8'h00};
    tv[3].w = 32'hFF00A55A; tv[3].b = '{8'h5A, 8'hA5, 8'h00, 8'hFF};

    // reset state, with a word waiting in the FIFO
    @(negedge clk);
    push_raw(32'h12345678);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    wr_ptr = rd_ptr;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_rd_en", 32'(fifo_rd_en), 32'd0);

    // back-to-back blocks
    run_stream(0, 256, 3000, "b2b", nl);
    chk("b2b_last_cnt", 32'(nl), 32'd2);

    // single-word table vectors
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      m_ready = 1'b1;
      base = rd_cnt;
      push_raw(tv[v].w);
      #1 chk("tv_rd_en", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      chk("tv_lat_valid", 32'(m_valid), 32'd0);
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        chk("tv_valid", 32'(m_valid), 32'd1);
`ifdef SD_RD_MSB_FIRST_EN
        chk("tv_byte", 32'(m_data), 32'(tv[v].b[NB-1-k]));
`else
        chk("tv_byte", 32'(m_data), 32'(tv[v].b[k]));
`endif
        chk("tv_last", 32'(m_last), (blk_idx == BLK - 1) ? 32'd1 : 32'd0);
        blk_idx = (blk_idx + 1) % BLK;
      end
      @(negedge clk);
      chk("tv_end_valid", 32'(m_valid), 32'd0);
      chk("tv_reads", 32'(rd_cnt - base), 32'd1);
    end

    // backpressure with a full FIFO
    run_stream(1, 40, 2000, "bp", nl);

    // random readiness and random FIFO arrivals
    run_stream(2, 150, 5000, "rnd", nl);

    // flush the cycle after a read, mid-stream
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word($urandom);
    hit = 1'b0;
    seen_v = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (seen_v && fifo_rd_en) hit = 1'b1;
      if (m_valid) begin
        take("fl_pre");
        seen_v = 1'b1;
      end
      @(negedge clk);
    end
    chk("fl_found", 32'(hit), 32'd1);
    flush = 1'b1;
    #1 chk("fl_rd_blocked", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    wr_ptr = rd_ptr;
    exp_q.delete();
    blk_idx = 0;
    #1 chk("fl_valid_next", 32'(m_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("fl_idle", 32'(m_valid), 32'd0);
    end
    run_stream(0, 130, 2000, "fl_post", nl);
    chk("fl_last_cnt", 32'(nl), 32'd1);

    // reset mid-stream at lane 2
    @(negedge clk);
    m_ready = 1'b1;
    push_word($urandom);
    push_word($urandom);
    hsn = 0;
    for (int c = 0; c < 20 && hsn < 2; c++) begin
      if (m_valid) begin
        take("rs_pre");
        hsn++;
      end
      @(negedge clk);
    end
    chk("rs_reached", 32'(hsn), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rs_valid", 32'(m_valid), 32'd0);
    chk("rs_data", 32'(m_data), 32'd0);
    chk("rs_last", 32'(m_last), 32'd0);
    chk("rs_rd_en", 32'(fifo_rd_en), 32'd0);
    wr_ptr = rd_ptr;
    exp_q.delete();
    blk_idx = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_word($urandom);
    #1 chk("rs_rd_in_reset", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rs_rd_at_release", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    chk("rs_rd_after", 32'(fifo_rd_en), 32'd1);
    run_stream(0, 0, 200, "rs_post", nl);

    chk("fifo_underflow", 32'(rd_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
